// File: rtl/delay_pipe.sv
// -----------------------------------------------------------------------------
// delay_pipe
//
// Flow-controlled fixed-latency delay line. A DATA_W-bit payload with a valid
// qualifier travels through DEPTH register stages. The last stage is the output
// register. Used between datapath units to align operand streams whose
// producers and consumers may stall.
//
// Features:
//   - ready/valid backpressure on both sides
//   - synchronous flush (clears every valid bit, leaves data registers alone)
//   - registered occupancy count
//   - optional bubble collapsing, enabled by defining
//     DELAY_PIPE_BUBBLE_COLLAPSE_EN. When it is undefined, a stalled output
//     freezes the whole pipe, bubbles included.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of all stages
//   in_data    input payload
//   in_valid   input beat present
//   in_ready   stage 0 can load this cycle (combinational, independent of in_valid)
//   out_data   stage DEPTH-1 payload (register output)
//   out_valid  stage DEPTH-1 valid (register output)
//   out_ready  consumer accepts the output beat
//   count      number of valid stages (register output)
// -----------------------------------------------------------------------------
module delay_pipe #(
    parameter  int DATA_W = 14,
    parameter  int DEPTH  = 9,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] d_reg [DEPTH];
    logic [DATA_W-1:0] d_src [DEPTH];
    logic [DEPTH-1:0]  v_reg;
    logic [DEPTH-1:0]  v_src;
    logic [DEPTH-1:0]  v_next;
    logic [DEPTH-1:0]  adv;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              accepted;
    logic              taken;

    genvar gi;

`ifdef DELAY_PIPE_BUBBLE_COLLAPSE_EN
    // A stage may load when it is empty or when its occupant moves on. Unrolled,
    // stage gi can advance whenever the output drains or any stage from gi to
    // the output is empty. Written in closed form so there is no
    // bit-to-bit combinational chain through one vector.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_adv
            assign adv[gi] = out_ready | ~(&v_reg[DEPTH-1:gi]);
        end
    endgenerate
`else
    // Global stall: every stage moves together, so bubbles keep their spacing.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_adv
            assign adv[gi] = out_ready | ~v_reg[DEPTH-1];
        end
    endgenerate
`endif

    // Each stage's load source: the input port for stage 0, else its upstream neighbour.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_src
            if (gi == 0) begin : g_head
                assign d_src[gi] = in_data;
                assign v_src[gi] = in_valid;
            end else begin : g_body
                assign d_src[gi] = d_reg[gi-1];
                assign v_src[gi] = v_reg[gi-1];
            end
        end
    endgenerate

    // While flush is high, in_ready is 0, so stage 0 never captures a beat
    // that the count would miss.
    assign in_ready  = rst_n & adv[0] & ~flush;
    assign accepted  = in_valid & in_ready;
    assign taken     = out_valid & out_ready;

    always_comb begin
        v_next = v_reg;
        if (flush) begin
            v_next = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i]) begin
                    v_next[i] = v_src[i];
                end
            end
        end
    end

    // A beat taken during a flush still counts as delivered. The flush result
    // is 0 either way.
    always_comb begin
        count_next = count_reg + CNT_W'(accepted) - CNT_W'(taken);
        if (flush) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_reg     <= '0;
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_reg[i] <= '0;
            end
        end else begin
            v_reg     <= v_next;
            count_reg <= count_next;
            // Data registers keep their contents across a flush. Only the
            // valid bits clear.
            if (!flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (adv[i]) begin
                        d_reg[i] <= d_src[i];
                    end
                end
            end
        end
    end

    assign out_data  = d_reg[DEPTH-1];
    assign out_valid = v_reg[DEPTH-1];
    assign count     = count_reg;

endmodule

// File: tb/tb_delay_pipe.sv
// -----------------------------------------------------------------------------
// tb_delay_pipe
//
// Self-checking bench for delay_pipe in its default (global-stall) build.
//
// Main instance (DATA_W=14, DEPTH=9): a reference model tracks every beat in
// flight as {data, age}. Age is the number of pipe advances since the beat was
// accepted. The beat is on the output when its age reaches DEPTH-1. A stalled
// output freezes all ages.
//
// Small instance (DATA_W=1, DEPTH=2): a plain FIFO scoreboard checks ordered,
// lossless delivery under random traffic.
// -----------------------------------------------------------------------------
module tb_delay_pipe;

    localparam int DW = 14;
    localparam int DP = 9;
    localparam int CW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;

    logic          s_flush;
    logic [0:0]    s_in_data;
    logic          s_in_valid;
    logic          s_in_ready;
    logic [0:0]    s_out_data;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [1:0]    s_count;

    always #5 clk = ~clk;

    delay_pipe #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    delay_pipe #(.DATA_W(1), .DEPTH(2)) dut_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (s_flush),
        .in_data   (s_in_data),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .out_data  (s_out_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .count     (s_count)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            age;
    } beat_t;

    beat_t         mq[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;
    bit            last_acc;
    bit            last_dut_ov;
    bit            last_dut_ir;
    logic [DW-1:0] last_dut_od;
    logic [CW-1:0] last_dut_cnt;

    // One clock cycle. Compare the DUT with the model at the falling edge,
    // then step the model across the rising edge.
    task automatic tick();
        bit            m_ov;
        bit            m_stall;
        bit            m_ir;
        bit            m_take;
        logic [DW-1:0] m_od;
        @(negedge clk);
        m_ov    = (mq.size() > 0) && (mq[0].age == DP - 1);
        m_od    = m_ov ? mq[0].data : '0;
        m_stall = m_ov && !out_ready;
        m_ir    = !m_stall && !flush;
        n_checks++;
        if (in_ready !== m_ir) $display("FAIL cyc=%0d in_ready got=%b want=%b", cyc, in_ready, m_ir);
        else n_pass++;
        n_checks++;
        if (out_valid !== m_ov) $display("FAIL cyc=%0d out_valid got=%b want=%b", cyc, out_valid, m_ov);
        else n_pass++;
        n_checks++;
        if (count !== CW'(mq.size())) $display("FAIL cyc=%0d count got=%0d want=%0d", cyc, count, mq.size());
        else n_pass++;
        if (m_ov) begin
            n_checks++;
            if (out_data !== m_od) $display("FAIL cyc=%0d out_data got=%h want=%h", cyc, out_data, m_od);
            else n_pass++;
        end
        last_dut_ov  = out_valid;
        last_dut_ir  = in_ready;
        last_dut_od  = out_data;
        last_dut_cnt = count;
        last_acc     = in_valid && m_ir;
        m_take       = m_ov && out_ready;
        @(posedge clk);
        if (m_take) void'(mq.pop_front());
        if (flush) begin
            mq.delete();
        end else if (!m_stall) begin
            foreach (mq[k]) mq[k].age++;
            if (last_acc) mq.push_back('{data: in_data, age: 0});
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset out_valid got=%b want=0", out_valid); else n_pass++;
        n_checks++;
        if (out_data !== '0) $display("FAIL reset out_data got=%h want=0", out_data); else n_pass++;
        n_checks++;
        if (count !== '0) $display("FAIL reset count got=%0d want=0", count); else n_pass++;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL reset in_ready got=%b want=0", in_ready); else n_pass++;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        $display("reset: released at cyc %0d", cyc);
    endtask

    task automatic test_stream();
        logic [DW-1:0] got[$];
        int            got_cyc[$];
        int            first_acc = -1;
        int            first_ov  = -1;
        int            max_cnt   = 0;
        int            guard     = 0;
        int            t;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i + 1);
            t = cyc;
            tick();
            if (last_acc && first_acc < 0) first_acc = t;
            if (last_dut_ov && first_ov < 0) first_ov = t;
            if (last_dut_ov) begin got.push_back(last_dut_od); got_cyc.push_back(t); end
            if (int'(last_dut_cnt) > max_cnt) max_cnt = int'(last_dut_cnt);
        end
        in_valid = 1'b0;
        while (mq.size() > 0 && guard < 40) begin
            t = cyc;
            tick();
            guard++;
            if (last_dut_ov && first_ov < 0) first_ov = t;
            if (last_dut_ov) begin got.push_back(last_dut_od); got_cyc.push_back(t); end
            if (int'(last_dut_cnt) > max_cnt) max_cnt = int'(last_dut_cnt);
        end
        tick();
        n_checks++;
        if (first_ov - first_acc !== DP) $display("FAIL stream latency got=%0d want=%0d", first_ov - first_acc, DP); else n_pass++;
        n_checks++;
        if (got.size() !== 20) $display("FAIL stream beat_count got=%0d want=20", got.size()); else n_pass++;
        for (int k = 0; k < got.size() && k < 20; k++) begin
            n_checks++;
            if (got[k] !== DW'(k + 1)) $display("FAIL stream order idx=%0d got=%h want=%h", k, got[k], DW'(k + 1)); else n_pass++;
        end
        if (got.size() == 20) begin
            n_checks++;
            if (got_cyc[19] - got_cyc[0] !== 19) $display("FAIL stream consecutive span got=%0d want=19", got_cyc[19] - got_cyc[0]); else n_pass++;
        end
        n_checks++;
        if (max_cnt !== DP) $display("FAIL stream max_count got=%0d want=%0d", max_cnt, DP); else n_pass++;
        n_checks++;
        if (last_dut_cnt !== '0) $display("FAIL stream drained_count got=%0d want=0", last_dut_cnt); else n_pass++;
        $display("stream: %0d beats out, latency %0d, max count %0d", got.size(), first_ov - first_acc, max_cnt);
    endtask

    task automatic test_hold();
        int takes = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 14'h3FFF;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < DP; i++) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (last_dut_ov !== 1'b1 || last_dut_od !== 14'h3FFF)
                $display("FAIL hold stall%0d out got=%b/%h want=1/3fff", i, last_dut_ov, last_dut_od);
            else n_pass++;
            n_checks++;
            if (last_dut_cnt !== CW'(1)) $display("FAIL hold stall%0d count got=%0d want=1", i, last_dut_cnt); else n_pass++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (last_dut_ov) takes++;
        end
        n_checks++;
        if (takes !== 1) $display("FAIL hold takes got=%0d want=1", takes); else n_pass++;
        n_checks++;
        if (last_dut_cnt !== '0) $display("FAIL hold final_count got=%0d want=0", last_dut_cnt); else n_pass++;
        $display("hold: takes after release %0d", takes);
    endtask

    task automatic test_alternating();
        logic [DW-1:0] sent[8];
        logic [DW-1:0] got[$];
        int            idx    = 0;
        bit            gap    = 1'b0;
        int            a0     = -1;
        int            guard  = 0;
        int            stalls = 0;
        for (int k = 0; k < 8; k++) sent[k] = DW'($urandom);
        while ((idx < 8 || mq.size() > 0) && guard < 100) begin
            in_valid  = (idx < 8) && !gap;
            in_data   = (idx < 8) ? sent[idx] : '0;
            out_ready = !(a0 >= 0 && cyc - a0 >= DP && cyc - a0 < DP + 6);
            tick();
            guard++;
            if (!out_ready) begin
                stalls++;
                n_checks++;
                if (last_dut_ir !== 1'b0) $display("FAIL alt stall in_ready got=%b want=0", last_dut_ir); else n_pass++;
                n_checks++;
                if (last_dut_cnt !== CW'(5)) $display("FAIL alt stall count got=%0d want=5", last_dut_cnt); else n_pass++;
            end
            if (last_dut_ov && out_ready) got.push_back(last_dut_od);
            if (last_acc) begin
                if (a0 < 0) a0 = cyc - 1;
                idx++;
                gap = 1'b1;
            end else begin
                gap = 1'b0;
            end
        end
        n_checks++;
        if (guard >= 100) $display("FAIL alt timeout got=%0d cycles want<100", guard); else n_pass++;
        n_checks++;
        if (stalls !== 6) $display("FAIL alt stall_cycles got=%0d want=6", stalls); else n_pass++;
        n_checks++;
        if (got.size() !== 8) $display("FAIL alt beat_count got=%0d want=8", got.size()); else n_pass++;
        for (int k = 0; k < got.size() && k < 8; k++) begin
            n_checks++;
            if (got[k] !== sent[k]) $display("FAIL alt order idx=%0d got=%h want=%h", k, got[k], sent[k]); else n_pass++;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        $display("alternating: %0d beats out, %0d stall cycles", got.size(), stalls);
    endtask

    task automatic test_flush();
        logic [DW-1:0] sent[6];
        int            leaks = 0;
        for (int k = 0; k < 6; k++) sent[k] = DW'($urandom_range(0, 16'h1FFF));
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = sent[k];
            tick();
        end
        in_valid = 1'b0;
        for (int k = 6; k < DP; k++) tick();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 14'h2AAA;
        tick();
        n_checks++;
        if (last_dut_ir !== 1'b0) $display("FAIL flush in_ready got=%b want=0", last_dut_ir); else n_pass++;
        n_checks++;
        if (last_dut_ov !== 1'b1 || last_dut_od !== sent[0])
            $display("FAIL flush taken_beat got=%b/%h want=1/%h", last_dut_ov, last_dut_od, sent[0]);
        else n_pass++;
        n_checks++;
        if (last_dut_cnt !== CW'(6)) $display("FAIL flush pre_count got=%0d want=6", last_dut_cnt); else n_pass++;
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (last_dut_cnt !== '0 || last_dut_ov !== 1'b0)
            $display("FAIL flush post count/valid got=%0d/%b want=0/0", last_dut_cnt, last_dut_ov);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (last_dut_ov) leaks++;
        end
        n_checks++;
        if (leaks !== 0) $display("FAIL flush leaked_beats got=%0d want=0", leaks); else n_pass++;
        $display("flush: leaked beats %0d", leaks);
    endtask

    task automatic test_reset_mid();
        int leaks = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            tick();
        end
        #2;
        n_checks++;
        if (count !== CW'(7)) $display("FAIL rstmid in_flight got=%0d want=7", count); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL rstmid out_valid got=%b want=0", out_valid); else n_pass++;
        n_checks++;
        if (out_data !== '0) $display("FAIL rstmid out_data got=%h want=0", out_data); else n_pass++;
        n_checks++;
        if (count !== '0) $display("FAIL rstmid count got=%0d want=0", count); else n_pass++;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL rstmid in_ready got=%b want=0", in_ready); else n_pass++;
        mq.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (last_dut_ov) leaks++;
        end
        n_checks++;
        if (leaks !== 0) $display("FAIL rstmid residual_beats got=%0d want=0", leaks); else n_pass++;
        $display("reset_mid: residual beats %0d", leaks);
    endtask

    task automatic test_random_small();
        logic sb[$];
        int   delivered = 0;
        for (int i = 0; i < 1010; i++) begin
            s_in_valid  = (i < 1000) ? 1'($urandom) : 1'b0;
            s_in_data   = 1'($urandom);
            s_out_ready = (i < 1000) ? 1'($urandom) : 1'b1;
            @(negedge clk);
            n_checks++;
            if (s_count !== 2'(sb.size())) $display("FAIL small cyc=%0d count got=%0d want=%0d", i, s_count, sb.size()); else n_pass++;
            n_checks++;
            if (s_count > 2'd2) $display("FAIL small cyc=%0d count_bound got=%0d want<=2", i, s_count); else n_pass++;
            if (s_out_valid && s_out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL small cyc=%0d spurious beat got=%b want=none", i, s_out_data);
                end else begin
                    if (s_out_data !== sb[0]) $display("FAIL small cyc=%0d data got=%b want=%b", i, s_out_data, sb[0]);
                    else n_pass++;
                    void'(sb.pop_front());
                    delivered++;
                end
            end
            if (s_in_valid && s_in_ready) sb.push_back(s_in_data[0]);
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (sb.size() !== 0) $display("FAIL small lost_beats got=%0d want=0", sb.size()); else n_pass++;
        n_checks++;
        if (delivered < 100) $display("FAIL small delivered got=%0d want>=100", delivered); else n_pass++;
        s_in_valid = 1'b0;
        $display("random_small: %0d beats delivered", delivered);
    endtask

    initial begin
        flush       = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        s_flush     = 1'b0;
        s_in_data   = '0;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        test_reset();
        test_stream();
        test_hold();
        test_alternating();
        test_flush();
        test_reset_mid();
        test_random_small();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
